// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl : one-at-a-time issue/response sequencer around the alu with a
// 2-entry register file. Optional overflow trap: define ALU_OVF_TRAP_EN.
// Rev 1.0
// ============================================================================
module alu_issue_ctrl #(
   parameter int          CNT_W      = 16,
   parameter logic [31:0] REG_INIT_A = 32'h0,
   parameter logic [31:0] REG_INIT_B = 32'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             cfg_we,
   input  logic             cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      alu_instruction,
   output logic [31:0]      alu_regA,
   output logic [31:0]      alu_regB,
   input  logic [31:0]      alu_result,
   input  logic [2:0]       alu_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [2:0]       out_flags,
   output logic             out_err,
   output logic             out_wb,
   output logic [CNT_W-1:0] instr_count
`ifdef ALU_OVF_TRAP_EN
   ,
   output logic             trap
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             started_q, started_d;
   logic [31:0]      instr_q, instr_d;
   logic             illegal_q, illegal_d;
   logic [31:0]      reg_a_q, reg_a_d;
   logic [31:0]      reg_b_q, reg_b_d;
   logic [31:0]      res_q, res_d;
   logic [2:0]       flags_q, flags_d;
   logic             err_q, err_d;
   logic             wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_OVF_TRAP_EN
   logic             trap_q, trap_d;
`endif

   logic [5:0] op, funct;
   logic [4:0] dest;
   logic       r_alu, i_alu, ovf_block, wb_ok;

   // Write-back eligibility of the latched instruction.
   always_comb begin
      op    = instr_q[31:26];
      funct = instr_q[5:0];
      dest  = (op == 6'h00) ? instr_q[15:11] : instr_q[20:16];
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B: r_alu = (op == 6'h00);
         default:      r_alu = 1'b0;
      endcase
      i_alu = (op >= 6'h08) && (op <= 6'h0E);
`ifdef ALU_OVF_TRAP_EN
      ovf_block = alu_flags[0];
`else
      ovf_block = 1'b0;
`endif
      wb_ok = (r_alu || i_alu) && (dest[4:1] == 4'd0) && !ovf_block;
   end

   always_comb begin
      state_d         = state_q;
      started_d       = 1'b1;
      instr_d         = instr_q;
      illegal_d       = illegal_q;
      reg_a_d         = reg_a_q;
      reg_b_d         = reg_b_q;
      res_d           = res_q;
      flags_d         = flags_q;
      err_d           = err_q;
      wb_d            = wb_q;
      cnt_d           = cnt_q;
`ifdef ALU_OVF_TRAP_EN
      trap_d          = trap_q;
`endif
      in_ready        = started_q && (state_q == IDLE) && !cfg_we;
      alu_instruction = 32'h0;
      alu_regA        = reg_a_q;
      alu_regB        = reg_b_q;

      case (state_q)
         IDLE: begin
            if (cfg_we) begin
               if (cfg_addr) reg_b_d = cfg_wdata;
               else          reg_a_d = cfg_wdata;
`ifdef ALU_OVF_TRAP_EN
               trap_d = 1'b0;
`endif
            end else if (in_valid && in_ready) begin
               instr_d   = in_instr;
               illegal_d = (in_instr[25:22] != 4'd0) || (in_instr[20:17] != 4'd0);
               state_d   = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
            if (illegal_q) begin
               res_d   = 32'h0;
               flags_d = 3'b000;
               err_d   = 1'b1;
               wb_d    = 1'b0;
            end else begin
               alu_instruction = instr_q;
               res_d   = alu_result;
               flags_d = alu_flags;
               err_d   = 1'b0;
               wb_d    = wb_ok;
               if (wb_ok) begin
                  if (dest[0]) reg_b_d = alu_result;
                  else         reg_a_d = alu_result;
               end
`ifdef ALU_OVF_TRAP_EN
               if (alu_flags[0]) trap_d = 1'b1;
`endif
            end
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         started_q <= 1'b0;
         instr_q   <= 32'h0;
         illegal_q <= 1'b0;
         reg_a_q   <= REG_INIT_A;
         reg_b_q   <= REG_INIT_B;
         res_q     <= 32'h0;
         flags_q   <= 3'b000;
         err_q     <= 1'b0;
         wb_q      <= 1'b0;
         cnt_q     <= '0;
`ifdef ALU_OVF_TRAP_EN
         trap_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         started_q <= started_d;
         instr_q   <= instr_d;
         illegal_q <= illegal_d;
         reg_a_q   <= reg_a_d;
         reg_b_q   <= reg_b_d;
         res_q     <= res_d;
         flags_q   <= flags_d;
         err_q     <= err_d;
         wb_q      <= wb_d;
         cnt_q     <= cnt_d;
`ifdef ALU_OVF_TRAP_EN
         trap_q    <= trap_d;
`endif
      end
   end

   assign out_valid   = (state_q == RESP);
   assign out_result  = res_q;
   assign out_flags   = flags_q;
   assign out_err     = err_q;
   assign out_wb      = wb_q;
   assign instr_count = cnt_q;
`ifdef ALU_OVF_TRAP_EN
   assign trap        = trap_q;
`endif

endmodule
`default_nettype wire
